// File: rtl/flash_pkg.sv
// Shared MMIO map, colour codes and sequencer state encoding for the LED flash block.
package flash_pkg;

    localparam logic [11:0] RAND_ADDR   = 12'd5;
    localparam logic [11:0] FLASH_ADDR  = 12'd6;
    localparam logic [11:0] FLUSH_ADDR  = 12'd7;
    localparam logic [11:0] STATUS_ADDR = 12'd8;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] BLUE   = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;
    localparam logic [1:0] YELLOW = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } flash_state_t;

    // One-hot LED vector ordered {yellow, green, blue, red}
    function automatic logic [3:0] led_decode(input logic [1:0] colour);
        return 4'b0001 << colour;
    endfunction

endpackage

// File: rtl/flash_fifo.sv
// Colour queue: 2-bit synchronous FIFO with occupancy count and single-cycle flush.
module flash_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [1:0]    din,
    output logic [1:0]    dout,
    output logic [CW-1:0] count,
    output logic          full
);

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    // A full queue still accepts when the head leaves this cycle; the new tail reuses its slot
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push && !reset && !flush)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/flash_sequencer.sv
// LED flash scheduler: queues colour stores from dmem and plays each as an ON pulse then a dark gap.
module flash_sequencer
    import flash_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int ON_CYCLES  = 12500000,
    parameter int GAP_CYCLES = 6250000,
    parameter int CNT_W      = 24
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wren,
    input  logic [11:0] address_dmem,
    input  logic [31:0] data,
    output logic [31:0] status,
    output logic        red_led,
    output logic        blue_led,
    output logic        green_led,
    output logic        yellow_led,
    output logic        busy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    flash_state_t   state, state_nxt;
    logic [CNT_W-1:0] timer, timer_nxt;
    logic [1:0]     colour, colour_nxt, head;
    logic [3:0]     led_q, led_nxt;
    logic [CW-1:0]  count;
    logic           full, pop, push_req, flush_req, overflow, have;
    logic           unused_data;

    assign unused_data = ^data[31:2];
    assign flush_req   = wren && (address_dmem == FLUSH_ADDR) && data[0];
    assign push_req    = wren && (address_dmem == FLASH_ADDR) && !flush_req;
    assign have        = (count != '0);

    flash_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (flush_req),
        .push  (push_req),
        .pop   (pop),
        .din   (data[1:0]),
        .dout  (head),
        .count (count),
        .full  (full)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            timer    <= '0;
            colour   <= RED;
            led_q    <= '0;
            overflow <= 1'b0;
        end else begin
            state  <= state_nxt;
            timer  <= timer_nxt;
            colour <= colour_nxt;
            led_q  <= led_nxt;
            if (flush_req)
                overflow <= 1'b0;
            else if (push_req && full && !pop)
                overflow <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        if (flush_req) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (have) begin
                    pop       = 1'b1;
                    state_nxt = ST_ON;
                end
                ST_ON:   if (timer == '0) state_nxt = ST_GAP;
                ST_GAP:  if (timer == '0) begin
                    pop       = have;
                    state_nxt = have ? ST_ON : ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        timer_nxt  = timer;
        colour_nxt = colour;
        if (flush_req) begin
            timer_nxt = '0;
        end else if (pop) begin
            timer_nxt  = ON_LOAD;
            colour_nxt = head;
        end else if (state == ST_ON && timer == '0) begin
            timer_nxt = GAP_LOAD;
        end else if (state != ST_IDLE && timer != '0) begin
            timer_nxt = timer - CNT_W'(1);
        end
        // Registering the next-state decode puts the LED edge on the same clock as the pop
        led_nxt = (state_nxt == ST_ON) ? led_decode(colour_nxt) : 4'b0000;

        busy           = (state != ST_IDLE) || have;
        status         = '0;
        status[CW-1:0] = count;
        status[8]      = overflow;
        status[9]      = busy;
        status[10]     = full;
    end

    assign {yellow_led, green_led, blue_led, red_led} = led_q;

endmodule
